// File: rtl/morse_char_decoder.sv
// Morse symbol-stream to character decoder: collects DOT/DASH into a pattern,
// commits on GAP or idle timeout, and keeps a four-character history.
module morse_char_decoder #(
   parameter int TIMEOUT = 150
) (
   input  logic        clock100Hz,
   input  logic        clear,
   input  logic [1:0]  sym_type,
   output logic [5:0]  char_code,
   output logic        char_valid,
   output logic        char_err,
   output logic [23:0] history
);

   localparam logic [1:0] T_GAP  = 2'b00;
   localparam logic [1:0] T_DOT  = 2'b01;
   localparam logic [1:0] T_DASH = 2'b10;
   localparam logic [1:0] T_STOP = 2'b11;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [5:0] BAD = 6'd63;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t     state;
   logic [4:0] pat;
   logic [2:0] len;
   logic       ovf;
   logic [7:0] timer;

   logic       is_sym;
   logic       commit;
   logic [5:0] code_c;

   // Pattern bits are read MSB-first over len bits, DOT = 0, DASH = 1.
   function automatic logic [5:0] lookup(input logic [2:0] n, input logic [4:0] p);
      logic [5:0] c;
      c = BAD;
      case (n)
         3'd1: c = p[0] ? 6'd19 : 6'd4;
         3'd2: case (p[1:0])
            2'b00: c = 6'd8;
            2'b01: c = 6'd0;
            2'b10: c = 6'd13;
            default: c = 6'd12;
         endcase
         3'd3: case (p[2:0])
            3'b000: c = 6'd18;
            3'b001: c = 6'd20;
            3'b010: c = 6'd17;
            3'b011: c = 6'd22;
            3'b100: c = 6'd3;
            3'b101: c = 6'd10;
            3'b110: c = 6'd6;
            default: c = 6'd14;
         endcase
         3'd4: case (p[3:0])
            4'b0000: c = 6'd7;
            4'b0001: c = 6'd21;
            4'b0010: c = 6'd5;
            4'b0100: c = 6'd11;
            4'b0110: c = 6'd15;
            4'b0111: c = 6'd9;
            4'b1000: c = 6'd1;
            4'b1001: c = 6'd23;
            4'b1010: c = 6'd2;
            4'b1011: c = 6'd24;
            4'b1100: c = 6'd25;
            4'b1101: c = 6'd16;
            default: c = BAD;
         endcase
         3'd5: case (p)
            5'b11111: c = 6'd26;
            5'b01111: c = 6'd27;
            5'b00111: c = 6'd28;
            5'b00011: c = 6'd29;
            5'b00001: c = 6'd30;
            5'b00000: c = 6'd31;
            5'b10000: c = 6'd32;
            5'b11000: c = 6'd33;
            5'b11100: c = 6'd34;
            5'b11110: c = 6'd35;
            default:  c = BAD;
         endcase
         default: c = BAD;
      endcase
      return c;
   endfunction

   always_comb begin
      is_sym = (sym_type == T_DOT) || (sym_type == T_DASH);
      commit = (state == COLLECT) &&
               ((sym_type == T_GAP) || ((sym_type == T_STOP) && (timer == TMO_LAST)));
      code_c = ovf ? BAD : lookup(len, pat);
   end

   always_ff @(posedge clock100Hz) begin
      if (!clear) begin
         state      <= IDLE;
         pat        <= '0;
         len        <= '0;
         ovf        <= 1'b0;
         timer      <= '0;
         char_code  <= '0;
         char_valid <= 1'b0;
         char_err   <= 1'b0;
         history    <= 24'hFFFFFF;
      end else begin
         char_valid <= 1'b0;
         char_err   <= 1'b0;
         // A symbol beats a timeout landing on the same cycle.
         if (is_sym) begin
            if (len < 3'd5) begin
               pat   <= {pat[3:0], (sym_type == T_DASH)};
               len   <= len + 3'd1;
               state <= COLLECT;
            end else begin
               ovf <= 1'b1;
            end
            timer <= '0;
         end else if (commit) begin
            char_code  <= code_c;
            char_valid <= 1'b1;
            char_err   <= (code_c == BAD);
            history    <= {history[17:0], code_c};
            pat        <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            timer      <= '0;
            state      <= IDLE;
         end else if ((state == COLLECT) && (sym_type == T_STOP)) begin
            timer <= timer + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Randomized bench for morse_char_decoder against a string-based Morse reference model.
module tb_morse_char_decoder;
   localparam int TIMEOUT = 150;
   localparam logic [1:0] GAP = 2'b00, DOT = 2'b01, DASH = 2'b10, STOP = 2'b11;

   logic        clock100Hz = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  sym_type = STOP;
   logic [5:0]  char_code;
   logic        char_valid;
   logic        char_err;
   logic [23:0] history;

   morse_char_decoder #(.TIMEOUT(TIMEOUT)) dut (
      .clock100Hz (clock100Hz),
      .clear      (clear),
      .sym_type   (sym_type),
      .char_code  (char_code),
      .char_valid (char_valid),
      .char_err   (char_err),
      .history    (history)
   );

   always #5 clock100Hz = ~clock100Hz;

   int checks = 0;
   int errors = 0;

   // Index in this table is the character code; entries are DOT=0/DASH=1 strings.
   string morse [36] = '{
      "01","1000","1010","100","0","0010","110","0000","00","0111","101","0100","11",
      "10","111","0110","1101","010","000","1","001","0001","011","1001","1011","1100",
      "11111","01111","00111","00011","00001","00000","10000","11000","11100","11110"};

   string       m_cur;
   int          m_n, m_idle;
   logic [5:0]  m_code;
   logic        m_valid, m_err;
   logic [23:0] m_hist;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_code(input string s);
      for (int i = 0; i < 36; i++)
         if (morse[i] == s) return i;
      return 63;
   endfunction

   task automatic model_step(input logic c, input logic [1:0] t);
      int code;
      if (!c) begin
         m_cur = ""; m_n = 0; m_idle = 0;
         m_code = 0; m_valid = 0; m_err = 0; m_hist = 24'hFFFFFF;
         return;
      end
      m_valid = 0; m_err = 0;
      if (t == DOT || t == DASH) begin
         m_n++;
         if (m_n <= 5) m_cur = {m_cur, (t == DASH) ? "1" : "0"};
         m_idle = 0;
      end else if (m_n > 0 && (t == GAP || m_idle == TIMEOUT - 1)) begin
         code    = (m_n > 5) ? 63 : ref_code(m_cur);
         m_code  = 6'(code);
         m_valid = 1;
         m_err   = (code == 63);
         m_hist  = {m_hist[17:0], m_code};
         m_cur = ""; m_n = 0; m_idle = 0;
      end else if (m_n > 0) begin
         m_idle++;
      end
   endtask

   task automatic cyc(input logic c, input logic [1:0] t);
      clear = c; sym_type = t;
      @(posedge clock100Hz);
      model_step(c, t);
      @(negedge clock100Hz);
      check("code",  char_code,  m_code);
      check("valid", char_valid, m_valid);
      check("err",   char_err,   m_err);
      check("hist",  history,    m_hist);
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) cyc(1, (s[i] == "1") ? DASH : DOT);
   endtask

   logic [23:0] h_save;
   int          dens;

   initial begin
      m_cur = ""; m_n = 0; m_idle = 0; m_code = 0; m_valid = 0; m_err = 0; m_hist = 24'hFFFFFF;
      @(negedge clock100Hz);
      for (int i = 0; i < 3; i++) cyc(0, 2'($urandom_range(0, 3)));
      check("rst_code", char_code, 6'd0);
      check("rst_hist", history, 24'hFFFFFF);

      send("01");   cyc(1, GAP); check("A", char_code, 6'd0);
      send("111");  cyc(1, GAP); check("O", char_code, 6'd14);
      check("hist_AO", history[11:0], {6'd0, 6'd14});

      send("00000"); cyc(1, GAP); check("d5", char_code, 6'd31); check("d5_err", char_err, 1'b0);
      send("0011");  cyc(1, GAP); check("bad", char_code, 6'd63); check("bad_err", char_err, 1'b1);

      send("111111"); cyc(1, GAP); check("ovf", char_code, 6'd63); check("ovf_err", char_err, 1'b1);
      send("0");      cyc(1, GAP); check("after_ovf", char_code, 6'd4);

      send("1");
      for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, STOP);
      check("tmo_early", char_valid, 1'b0);
      cyc(1, STOP);
      check("tmo_valid", char_valid, 1'b1); check("tmo_T", char_code, 6'd19);

      send("1");
      for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, STOP);
      cyc(1, DOT);
      check("tmo_sym_wins", char_valid, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1, STOP);
      cyc(1, GAP); check("N", char_code, 6'd13);

      send("0");  cyc(1, GAP); cyc(1, DASH); cyc(1, GAP);
      check("b2b_T", char_code, 6'd19);

      h_save = history;
      cyc(1, GAP);
      check("idle_gap_valid", char_valid, 1'b0); check("idle_gap_hist", history, h_save);

      send("0"); cyc(0, GAP);
      check("clr_gap_valid", char_valid, 1'b0); check("clr_gap_hist", history, 24'hFFFFFF);
      check("clr_gap_code", char_code, 6'd0);

      for (int b = 0; b < 8; b++) begin
         dens = (b % 2) ? 60 : 5;
         for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 999);
            cyc(($urandom_range(0, 799) != 0),
                (r < dens) ? DOT : (r < 2 * dens) ? DASH : (r < 2 * dens + dens / 2 + 2) ? GAP : STOP);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
